// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Data-memory responder with a word RAM, a 64-bit timer with a
//            compare interrupt and an optional UART TX (macro DMEM_UART_EN).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int          RAM_AW  = 10,
    parameter int          FIFO_AW = 3,
    parameter logic [15:0] CLK_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wmask,
    input  logic        dmem_we,
    output logic [31:0] dmem_rdata,
    output logic        uart_tx,
    output logic        irq_timer
);

    localparam logic [2:0] c_SEL_UART_STAT = 3'd1;
    localparam logic [2:0] c_SEL_TIME_LO   = 3'd2;
    localparam logic [2:0] c_SEL_TIME_HI   = 3'd3;
    localparam logic [2:0] c_SEL_TCMP_LO   = 3'd4;
    localparam logic [2:0] c_SEL_TCMP_HI   = 3'd5;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  mask);
        logic [31:0] res;
        res = old_v;
        for (int n = 0; n < 4; n++) begin
            if (mask[n]) res[8*n +: 8] = new_v[8*n +: 8];
        end
        return res;
    endfunction

    logic [2:0]        w_sel;
    logic              w_mmio_we;
    logic              w_ram_we;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [31:0]       w_stat;
    logic              w_unused_addr;

    assign w_sel         = dmem_addr[4:2];
    assign w_mmio_we     = dmem_we & dmem_addr[31];
    assign w_ram_we      = dmem_we & ~dmem_addr[31];
    assign w_ram_idx     = dmem_addr[RAM_AW+1:2];
    assign w_unused_addr = &{1'b0, dmem_addr[30:0]};

    // RAM contents are intentionally not reset.
    logic [31:0] r_mem [0:(1<<RAM_AW)-1];

    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (w_ram_we && dmem_wmask[n]) r_mem[w_ram_idx][8*n +: 8] <= dmem_wdata[8*n +: 8];
        end
    end

    logic [63:0] r_time;
    logic [63:0] r_tcmp;
    logic        r_irq;

    // A write to one timer half suppresses the carry between halves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_time <= 64'd0;
            r_tcmp <= {64{1'b1}};
            r_irq  <= 1'b0;
        end else begin
            r_irq <= (r_time >= r_tcmp);
            if (w_mmio_we && w_sel == c_SEL_TIME_LO) begin
                r_time <= {r_time[63:32], f_merge(r_time[31:0], dmem_wdata, dmem_wmask)};
            end else if (w_mmio_we && w_sel == c_SEL_TIME_HI) begin
                r_time <= {f_merge(r_time[63:32], dmem_wdata, dmem_wmask), r_time[31:0] + 32'd1};
            end else begin
                r_time <= r_time + 64'd1;
            end
            if (w_mmio_we && w_sel == c_SEL_TCMP_LO) r_tcmp[31:0]  <= f_merge(r_tcmp[31:0], dmem_wdata, dmem_wmask);
            if (w_mmio_we && w_sel == c_SEL_TCMP_HI) r_tcmp[63:32] <= f_merge(r_tcmp[63:32], dmem_wdata, dmem_wmask);
        end
    end

    assign irq_timer = r_irq;

`ifdef DMEM_UART_EN
    localparam logic [2:0]         c_SEL_UART_DATA = 3'd0;
    localparam logic [FIFO_AW:0]   c_FIFO_FULL     = (FIFO_AW+1)'(1 << FIFO_AW);
    localparam logic [1:0]         c_ST_IDLE       = 2'd0;
    localparam logic [1:0]         c_ST_START      = 2'd1;
    localparam logic [1:0]         c_ST_DATA       = 2'd2;
    localparam logic [1:0]         c_ST_STOP       = 2'd3;

    logic [7:0]         r_fifo [0:(1<<FIFO_AW)-1];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic [1:0]         r_state;
    logic [15:0]        r_div;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_div_end;

    assign w_full    = (r_count == c_FIFO_FULL);
    assign w_empty   = (r_count == '0);
    assign w_div_end = (r_div == CLK_DIV - 16'd1);
    assign w_push    = w_mmio_we & (w_sel == c_SEL_UART_DATA) & dmem_wmask[0] & ~w_full;
    assign w_pop     = ~w_empty & ((r_state == c_ST_IDLE) | ((r_state == c_ST_STOP) & w_div_end));

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= dmem_wdata[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
        end
    end

    // Stop-bit end with data pending chains straight into the next start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_div   <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= c_ST_START;
                        r_shift <= r_fifo[r_rptr];
                        r_div   <= 16'd0;
                        r_tx    <= 1'b0;
                    end
                end
                c_ST_START: begin
                    if (w_div_end) begin
                        r_state <= c_ST_DATA;
                        r_div   <= 16'd0;
                        r_bit   <= 3'd0;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_div <= r_div + 16'd1;
                    end
                end
                c_ST_DATA: begin
                    if (w_div_end) begin
                        r_div <= 16'd0;
                        if (r_bit == 3'd7) begin
                            r_state <= c_ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_div <= r_div + 16'd1;
                    end
                end
                c_ST_STOP: begin
                    if (w_div_end) begin
                        r_div <= 16'd0;
                        if (w_pop) begin
                            r_state <= c_ST_START;
                            r_shift <= r_fifo[r_rptr];
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 16'd1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign w_stat  = {29'd0, r_state != c_ST_IDLE, w_full, w_empty};
    assign uart_tx = r_tx;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = &{1'b0, CLK_DIV, 32'(FIFO_AW)};
    assign w_stat       = 32'd0;
    assign uart_tx      = 1'b1;
`endif

    always_comb begin
        dmem_rdata = 32'd0;
        if (!dmem_addr[31]) begin
            dmem_rdata = r_mem[w_ram_idx];
        end else begin
            case (w_sel)
                c_SEL_UART_STAT: dmem_rdata = w_stat;
                c_SEL_TIME_LO:   dmem_rdata = r_time[31:0];
                c_SEL_TIME_HI:   dmem_rdata = r_time[63:32];
                c_SEL_TCMP_LO:   dmem_rdata = r_tcmp[31:0];
                c_SEL_TCMP_HI:   dmem_rdata = r_tcmp[63:32];
                default:         dmem_rdata = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Scoreboard bench for dmem_responder against a cycle-level model
//            of the memory map, timer and UART line (follows DMEM_UART_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int          RAM_AW  = 10;
    localparam int          FIFO_AW = 3;
    localparam logic [15:0] CLK_DIV = 16'd4;
    localparam int          D       = 4;
    localparam int          FDEPTH  = 8;
`ifdef DMEM_UART_EN
    localparam bit UART_EN = 1'b1;
`else
    localparam bit UART_EN = 1'b0;
`endif

    localparam logic [31:0] A_DATA = 32'h8000_0000;
    localparam logic [31:0] A_STAT = 32'h8000_0004;
    localparam logic [31:0] A_TLO  = 32'h8000_0008;
    localparam logic [31:0] A_THI  = 32'h8000_000C;
    localparam logic [31:0] A_CLO  = 32'h8000_0010;
    localparam logic [31:0] A_CHI  = 32'h8000_0014;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] dmem_addr = A_TLO;
    logic [31:0] dmem_wdata = 32'd0;
    logic [3:0]  dmem_wmask = 4'd0;
    logic        dmem_we = 1'b0;
    logic [31:0] dmem_rdata;
    logic        uart_tx;
    logic        irq_timer;

    int vectors = 0;
    int miscompares = 0;
    bit started = 1'b0;

    dmem_responder #(.RAM_AW(RAM_AW), .FIFO_AW(FIFO_AW), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wmask(dmem_wmask), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
        .uart_tx(uart_tx), .irq_timer(irq_timer)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_mem [0:1023];
    logic [63:0] m_time;
    logic [63:0] m_tcmp;
    logic        m_irq;
    logic        m_tx;
    logic [7:0]  m_fq[$];
    logic [7:0]  m_byte;
    int          m_rem;

    logic [31:0] exp_q[$];
    string       name_q[$];

    function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    // Line level idx cycles into a frame: start, 8 data bits LSB first, stop.
    function automatic logic line_level(input logic [7:0] b, input int idx);
        if (idx < D) return 1'b0;
        if (idx < 9*D) return b[(idx-D)/D];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (!a[31]) return m_mem[a[11:2]];
        case (a[4:2])
            3'd1: return UART_EN ? {29'd0, m_rem != 0, m_fq.size() == FDEPTH, m_fq.size() == 0} : 32'd0;
            3'd2: return m_time[31:0];
            3'd3: return m_time[63:32];
            3'd4: return m_tcmp[31:0];
            3'd5: return m_tcmp[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [2:0]  sel;
        logic        mwe;
        logic [63:0] nt;
        bit          full_pre;
        bit          empty_pre;
        sel = dmem_addr[4:2];
        mwe = dmem_we && dmem_addr[31];
        if (dmem_we && !dmem_addr[31])
            m_mem[dmem_addr[11:2]] = merge32(m_mem[dmem_addr[11:2]], dmem_wdata, dmem_wmask);
        m_irq = (m_time >= m_tcmp);
        nt = m_time + 64'd1;
        if (mwe && sel == 3'd2) nt = {m_time[63:32], merge32(m_time[31:0], dmem_wdata, dmem_wmask)};
        if (mwe && sel == 3'd3) nt = {merge32(m_time[63:32], dmem_wdata, dmem_wmask), m_time[31:0] + 32'd1};
        if (mwe && sel == 3'd4) m_tcmp[31:0]  = merge32(m_tcmp[31:0], dmem_wdata, dmem_wmask);
        if (mwe && sel == 3'd5) m_tcmp[63:32] = merge32(m_tcmp[63:32], dmem_wdata, dmem_wmask);
        m_time = nt;
        if (UART_EN) begin
            full_pre  = (m_fq.size() == FDEPTH);
            empty_pre = (m_fq.size() == 0);
            if (m_rem <= 1) begin
                if (!empty_pre) begin
                    m_byte = m_fq.pop_front();
                    m_rem  = 10*D;
                end else begin
                    m_rem = 0;
                end
            end else begin
                m_rem--;
            end
            if (mwe && sel == 3'd0 && dmem_wmask[0] && !full_pre) m_fq.push_back(dmem_wdata[7:0]);
            m_tx = (m_rem == 0) ? 1'b1 : line_level(m_byte, 10*D - m_rem);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_time = 64'd0;
            m_tcmp = {64{1'b1}};
            m_irq  = 1'b0;
            m_tx   = 1'b1;
            m_rem  = 0;
            m_fq.delete();
        end else begin
            model_step();
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: drains pending read expectations and checks the line outputs every cycle.
    always @(negedge clk) begin
        if (started) begin
            while (exp_q.size() > 0) check32(name_q.pop_front(), dmem_rdata, exp_q.pop_front());
            check32("irq_timer", {31'd0, irq_timer}, {31'd0, m_irq});
            check32("uart_tx", {31'd0, uart_tx}, {31'd0, m_tx});
        end
    end

    // mode: 0 no rdata check, 1 model expectation, 2 constant expectation
    task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm,
                       input logic we, input int mode, input logic [31:0] cexp, input string name);
        @(posedge clk);
        #1;
        dmem_addr  = a;
        dmem_wdata = wd;
        dmem_wmask = wm;
        dmem_we    = we;
        if (mode != 0) begin
            exp_q.push_back(mode == 2 ? cexp : exp_read(a));
            name_q.push_back(name);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(A_TLO, 32'd0, 4'd0, 1'b0, 1, 32'd0, "idle_time_lo");
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    initial begin : main
        logic [31:0] a;
        int          r;
        bit          found;

        #1 rst = 1'b1;
        started = 1'b1;
        cyc(A_TLO, 32'd0, 4'd0, 1'b0, 2, 32'd0, "rst_time_lo");
        cyc(A_THI, 32'd0, 4'd0, 1'b0, 2, 32'd0, "rst_time_hi");
        cyc(A_CLO, 32'd0, 4'd0, 1'b0, 2, 32'hFFFF_FFFF, "rst_tcmp_lo");
        cyc(A_CHI, 32'd0, 4'd0, 1'b0, 2, 32'hFFFF_FFFF, "rst_tcmp_hi");
        cyc(A_STAT, 32'd0, 4'd0, 1'b0, 1, 32'd0, "rst_stat");
        @(negedge clk);
        #2 rst = 1'b0;

        // RAM lane merge, read-during-write and aliasing
        cyc(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 0, 32'd0, "");
        cyc(32'h12, 32'h0055_0000, 4'b0100, 1'b1, 0, 32'd0, "");
        cyc(32'h10, 32'd0, 4'd0, 1'b0, 2, 32'hDE55_BEEF, "ram_lane_merge");
        cyc(32'h10, 32'h1, 4'hF, 1'b1, 2, 32'hDE55_BEEF, "ram_read_during_write");
        cyc(32'h10, 32'd0, 4'd0, 1'b0, 2, 32'h1, "ram_after_write");
        cyc(32'h0, 32'hA5, 4'hF, 1'b1, 0, 32'd0, "");
        cyc(32'h1000, 32'd0, 4'd0, 1'b0, 2, 32'hA5, "ram_alias");
        for (int i = 1; i < 16; i++) cyc(i*4, $urandom, 4'hF, 1'b1, 0, 32'd0, "");

        // Timer compare: irq rises the cycle after TIME reaches 0x10
        pulse_reset();
        cyc(A_CHI, 32'd0, 4'hF, 1'b1, 1, 32'd0, "tcmp_hi_wr");
        cyc(A_CLO, 32'h10, 4'hF, 1'b1, 1, 32'd0, "tcmp_lo_wr");
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            cyc(A_TLO, 32'd0, 4'd0, 1'b0, 1, 32'd0, "time_lo");
            @(negedge clk);
            #1;
            if (irq_timer) begin
                found = 1'b1;
                check32("irq_rise_time", dmem_rdata, 32'h11);
            end
        end
        if (!found) check32("irq_rise_timeout", 32'd0, 32'd1);

`ifdef DMEM_UART_EN
        // Single frame 0x41 then idle status
        cyc(A_DATA, 32'h41, 4'b0001, 1'b1, 1, 32'd0, "push_41");
        idle(45);
        cyc(A_STAT, 32'd0, 4'd0, 1'b0, 2, 32'h1, "stat_after_frame");
        // Ten consecutive pushes: nine accepted, tenth dropped
        for (int i = 0; i < 10; i++) cyc(A_DATA, 32'h30 + i, 4'b0001, 1'b1, 1, 32'd0, "push_burst");
        cyc(A_STAT, 32'd0, 4'd0, 1'b0, 2, 32'h6, "stat_full_busy");
        idle(9*10*D + 10);
        cyc(A_STAT, 32'd0, 4'd0, 1'b0, 2, 32'h1, "stat_after_burst");
        // Reset in the middle of an all-zero frame
        cyc(A_DATA, 32'h00, 4'b0001, 1'b1, 1, 32'd0, "push_00");
        idle(15);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check32("rst_tx_immediate", {31'd0, uart_tx}, 32'd1);
        check32("rst_irq_immediate", {31'd0, irq_timer}, 32'd0);
        check32("rst_rdata_immediate", dmem_rdata, 32'd0);
        #1 rst = 1'b0;
`endif

        // Randomized traffic over RAM words 0..15 (with alias bits) and the MMIO page
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                a = $urandom & 32'h7FFF_F03F;
                cyc(a, $urandom, 4'($urandom), r < 30, 1, 32'd0, "rnd_ram");
            end else begin
                a = $urandom | 32'h8000_0000;
                cyc(a, $urandom, 4'($urandom), r < 75, 1, 32'd0, "rnd_mmio");
            end
        end
        idle(400);

        @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
